// File: rtl/msg_sched_ring_sync.sv
// SHA-256 message-schedule expander with four-phase lr/la input and rr/ra output.
// Holds a 16-word sliding window and emits N_WORDS schedule words per block.
module msg_sched_ring_sync #(
  parameter int N_WORDS = 64,
  parameter int CW      = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lr,
  output logic          la,
  input  logic [511:0]  din,
  output logic          rr,
  input  logic          ra,
  output logic [31:0]   dout,
  output logic [CW-1:0] idx,
  output logic          busy
);

  if (N_WORDS < 16 || N_WORDS > 64) begin : g_bad_n
    $error("msg_sched_ring_sync: N_WORDS must be 16..64");
  end
  if ((64'd1 << CW) <= 64'(N_WORDS)) begin : g_bad_cw
    $error("msg_sched_ring_sync: CW too narrow for N_WORDS");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LACK,
    S_EMIT,
    S_REQ,
    S_RACK
  } state_e;

  state_e        state_q, state_d;
  logic          la_q, la_d;
  logic          rr_q, rr_d;
  logic          busy_q, busy_d;
  logic [31:0]   dout_q, dout_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [31:0]   w_q [16];
  logic [31:0]   w_d [16];
  logic [31:0]   wnew;
  logic          last;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  assign wnew = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];
  assign last = (idx_q == CW'(N_WORDS - 1));

  always_comb begin
    state_d = state_q;
    la_d    = la_q;
    rr_d    = rr_q;
    busy_d  = busy_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    w_d     = w_q;
    unique case (state_q)
      S_IDLE: begin
        if (lr) begin
          for (int i = 0; i < 16; i++) begin
            w_d[i] = din[511-32*i -: 32];
          end
          idx_d   = '0;
          la_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = S_LACK;
        end
      end
      S_LACK: begin
        if (!lr) begin
          la_d    = 1'b0;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        // rr must not rise while the consumer still holds ra high
        if (!ra) begin
          dout_d  = (idx_q < CW'(16)) ? w_q[idx_q[3:0]] : wnew;
          rr_d    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ra) begin
          rr_d    = 1'b0;
          state_d = S_RACK;
        end
      end
      S_RACK: begin
        if (!ra) begin
          if (last) begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            // slide only once wnew has been emitted from the current window
            if (idx_q >= CW'(16)) begin
              for (int i = 0; i < 15; i++) begin
                w_d[i] = w_q[i+1];
              end
              w_d[15] = wnew;
            end
            idx_d   = idx_q + CW'(1);
            state_d = S_EMIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      la_q    <= 1'b0;
      rr_q    <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
      idx_q   <= '0;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      la_q    <= la_d;
      rr_q    <= rr_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 16; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign la   = la_q;
  assign rr   = rr_q;
  assign busy = busy_q;
  assign dout = dout_q;
  assign idx  = idx_q;

endmodule
